regfile_mp: RTL and testbench

- Parametrised multi-port integer register file: the next-generation regfile for the riscv-cpu example.
- Serves superscalar/dual-issue decode and writeback: N combinational read ports, M synchronous write ports.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback, bulk-cleared on flush) so decode can detect RAW hazards.
- Register 0 is hardwired to zero and never busy.

---
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a per-register
// busy scoreboard for RAW hazard detection in a dual-issue decode/writeback path.
//
// Optional feature macro: REGFILE_MP_BYPASS_EN
//   defined   -> same-cycle write-to-read forwarding on every read port
//   undefined -> reads return stored state only
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst_n        synchronous active-low reset (clears data and busy bits)
//   raddr        NUM_READ read addresses, port i at [i*AW +: AW]
//   rdata        NUM_READ combinational read data, port i at [i*XLEN +: XLEN]
//   rbusy        busy flag of the register addressed by each read port
//   we/waddr/wdata  NUM_WRITE synchronous write ports (highest port wins)
//   issue_valid  mark issue_rd pending (busy) at the next edge
//   issue_rd     destination register being issued
//   flush        clear all busy bits
//   any_busy     OR of all stored busy bits
module regfile_mp #(
  parameter  int unsigned XLEN      = 32,
  parameter  int unsigned NREGS     = 32,
  parameter  int unsigned NUM_READ  = 2,
  parameter  int unsigned NUM_WRITE = 1,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_READ*AW-1:0]    raddr,
  output logic [NUM_READ*XLEN-1:0]  rdata,
  output logic [NUM_READ-1:0]       rbusy,
  input  logic [NUM_WRITE-1:0]      we,
  input  logic [NUM_WRITE*AW-1:0]   waddr,
  input  logic [NUM_WRITE*XLEN-1:0] wdata,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rd,
  input  logic                      flush,
  output logic                      any_busy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Data next-state: later write ports overwrite earlier ones, x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      if (we[j] && (waddr[j*AW +: AW] != '0)) begin
        regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Busy next-state: writeback clears, issue sets (new producer wins), flush clears all.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      if (we[j] && (waddr[j*AW +: AW] != '0)) begin
        busy_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards any write, issue or flush of the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rdata[i*XLEN +: XLEN] = regs_q[raddr[i*AW +: AW]];
      rbusy[i]              = busy_q[raddr[i*AW +: AW]];
      if (raddr[i*AW +: AW] == '0) begin
        rdata[i*XLEN +: XLEN] = '0;
        rbusy[i]              = 1'b0;
      end
`ifdef REGFILE_MP_BYPASS_EN
      // Forward same-cycle write data; ascending loop lets the highest port win.
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW]) &&
            (raddr[i*AW +: AW] != '0)) begin
          rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          rbusy[i]              = issue_valid && (issue_rd == raddr[i*AW +: AW]);
        end
      end
`endif
    end
  end

  assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (XLEN=64, 3 read / 2 write ports):
// directed scenarios followed by randomized traffic against a reference model.
module tb_regfile_mp;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned NUM_READ  = 3;
  localparam int unsigned NUM_WRITE = 2;
  localparam int unsigned AW        = 5;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_READ*AW-1:0]    raddr;
  logic [NUM_READ*XLEN-1:0]  rdata;
  logic [NUM_READ-1:0]       rbusy;
  logic [NUM_WRITE-1:0]      we;
  logic [NUM_WRITE*AW-1:0]   waddr;
  logic [NUM_WRITE*XLEN-1:0] wdata;
  logic                      issue_valid;
  logic [AW-1:0]             issue_rd;
  logic                      flush;
  logic                      any_busy;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_READ(NUM_READ), .NUM_WRITE(NUM_WRITE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .any_busy(any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_READ*XLEN-1:0] rdata;
    logic [NUM_READ-1:0]      rbusy;
    logic                     any_busy;
    int                       phase;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   phase  = 0;

  // Architectural reference state.
  logic [XLEN-1:0] mdl_regs [NREGS];
  bit              mdl_busy [NREGS];
  bit              mdl_known = 1'b0;

  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_all_rd(input int a);
    for (int p = 0; p < int'(NUM_READ); p++) set_rd(p, a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_issue(input int a);
    issue_valid = 1'b1;
    issue_rd = AW'(a);
  endtask

  // Expected read view of the current inputs against the stored model state.
  function automatic exp_t predict();
    exp_t e;
    int   a;
    bit   hit;
    e.rdata = '0;
    e.rbusy = '0;
    e.any_busy = 1'b0;
    e.phase = phase;
    for (int r = 0; r < int'(NREGS); r++) e.any_busy = e.any_busy | mdl_busy[r];
    for (int i = 0; i < int'(NUM_READ); i++) begin
      a = int'(raddr[i*AW +: AW]);
      e.rdata[i*XLEN +: XLEN] = (a == 0) ? '0 : mdl_regs[a];
      e.rbusy[i] = (a == 0) ? 1'b0 : mdl_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
      hit = 1'b0;
      for (int j = int'(NUM_WRITE) - 1; j >= 0; j--) begin
        if (!hit && a != 0 && we[j] && int'(waddr[j*AW +: AW]) == a) begin
          hit = 1'b1;
          e.rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          e.rbusy[i] = issue_valid && (int'(issue_rd) == a);
        end
      end
`else
      hit = 1'b0;
`endif
    end
    return e;
  endfunction

  // Architectural effect of one clock edge.
  task automatic model_edge();
    int a;
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        mdl_regs[r] = '0;
        mdl_busy[r] = 1'b0;
      end
      mdl_known = 1'b1;
      return;
    end
    for (int j = 0; j < int'(NUM_WRITE); j++) begin
      a = int'(waddr[j*AW +: AW]);
      if (we[j] && a != 0) begin
        mdl_regs[a] = wdata[j*XLEN +: XLEN];
        mdl_busy[a] = 1'b0;
      end
    end
    if (issue_valid && issue_rd != '0) mdl_busy[int'(issue_rd)] = 1'b1;
    if (flush) for (int r = 0; r < int'(NREGS); r++) mdl_busy[r] = 1'b0;
  endtask

  // Issue current inputs for one cycle: queue the expectation, then advance.
  task automatic step();
    if (mdl_known) exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: outputs are always presented; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < int'(NUM_READ); i++) begin
        n_cmp++;
        if (rdata[i*XLEN +: XLEN] !== e.rdata[i*XLEN +: XLEN]) begin
          n_fail++;
          $display("FAIL rdata[%0d] phase %0d: got %h want %h", i, e.phase,
                   rdata[i*XLEN +: XLEN], e.rdata[i*XLEN +: XLEN]);
        end
        n_cmp++;
        if (rbusy[i] !== e.rbusy[i]) begin
          n_fail++;
          $display("FAIL rbusy[%0d] phase %0d: got %b want %b", i, e.phase,
                   rbusy[i], e.rbusy[i]);
        end
      end
      n_cmp++;
      if (any_busy !== e.any_busy) begin
        n_fail++;
        $display("FAIL any_busy phase %0d: got %b want %b", e.phase, any_busy, e.any_busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    idle();
    #1;

    // Reset, then every register reads zero and idle.
    phase = 1;
    step(); step();
    rst_n = 1'b1;
    for (int a = 1; a < int'(NREGS); a++) begin
      set_rd(0, a); set_rd(1, (a + 7) % 32); set_rd(2, (a + 19) % 32);
      step();
    end

    // Write to x0 is ignored.
    phase = 2;
    set_wr(0, 0, 64'hDEADBEEF); set_all_rd(0); step();
    idle(); step();

    // Write x5, reading it in the same cycle and the next.
    phase = 3;
    set_all_rd(5); set_wr(0, 5, 64'h12345678); step();
    idle(); step();

    // Same-address conflict: highest port wins.
    phase = 4;
    set_all_rd(7); set_wr(0, 7, 64'h1111); set_wr(1, 7, 64'h2222); step();
    idle(); step();

    // Scoreboard set/clear and issue-beats-write.
    phase = 5;
    set_all_rd(9); set_issue(9); step();
    idle(); step();
    set_wr(1, 9, 64'hA5A5); step();
    idle(); step();
    set_issue(9); set_wr(0, 9, 64'h5A5A); step();
    idle(); step();

    // Multiple pending, then flush overrides a same-cycle issue.
    phase = 6;
    set_wr(0, 9, 64'h0); step();
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 6);
    idle(); set_issue(3); step();
    idle(); set_issue(4); step();
    idle(); set_issue(6); step();
    idle(); flush = 1'b1; set_issue(8); set_rd(2, 8); step();
    idle(); step();

    // Reset mid-operation discards busy and a pending write.
    phase = 7;
    set_all_rd(10); set_issue(10); step();
    idle(); set_wr(0, 10, 64'hCAFE); rst_n = 1'b0; step();
    idle(); rst_n = 1'b1; step();

    // Randomized traffic.
    phase = 8;
    for (int c = 0; c < 1000; c++) begin
      idle();
      rst_n = ($urandom_range(0, 199) != 0);
      for (int j = 0; j < int'(NUM_WRITE); j++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(j, int'($urandom_range(0, 31)), {$urandom, $urandom});
      end
      if ($urandom_range(0, 9) < 3) set_issue(int'($urandom_range(0, 31)));
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < int'(NUM_READ); i++) begin
        if ($urandom_range(0, 3) == 0) set_rd(i, int'(waddr[($urandom_range(0, 1))*AW +: AW]));
        else if ($urandom_range(0, 5) == 0) set_rd(i, int'(issue_rd));
        else set_rd(i, int'($urandom_range(0, 31)));
      end
      step();
    end

    idle();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
